// File: rtl/loop_counter.sv
// Modulo-N loop index counter with terminal-count carry-out.
// Used for nested loops in the CNN accelerator control path.
module loop_counter #(
  parameter  int N     = 10,
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic             co,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Wrap only on an exact match; a forced out-of-range value simply increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign co = (cnt == LAST);

endmodule

// File: tb/tb_loop_counter.sv
// Directed self-checking bench for loop_counter with the default N=10.
module tb_loop_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       co;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;

  loop_counter #(.N(10)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .co  (co),
    .cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp_cnt, input logic exp_co);
    total++;
    assert (cnt === exp_cnt && co === exp_co)
    else begin
      bad++;
      $error("FAIL %s: got cnt=%0d co=%0b, expected cnt=%0d co=%0b", tag, cnt, co, exp_cnt, exp_co);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    #1;
    check("reset_async", 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset_hold1", 4'd0, 1'b0);
    tick();
    check("reset_hold2", 4'd0, 1'b0);

    // Count 1..9, co only at 9
    @(negedge clk);
    en = 1'b1;
    for (int unsigned i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("count_%0d", i), 4'(i), (i == 9));
    end

    // Wrap and second co pulse 10 clocks later
    tick();
    check("wrap", 4'd0, 1'b0);
    for (int unsigned i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("lap2_%0d", i), 4'(i), (i == 9));
    end

    // Park at terminal count
    @(negedge clk);
    en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("park_tc", 4'd9, 1'b1);
    end

    // Clear from terminal count, then count again
    @(negedge clk);
    clr = 1'b1;
    tick();
    check("clr_from_9", 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b1;
    for (int unsigned i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("after_clr_%0d", i), 4'(i), (i == 9));
    end
    tick();
    check("wrap2", 4'd0, 1'b0);
    for (int unsigned i = 1; i <= 5; i++) tick();
    check("reach_5", 4'd5, 1'b0);

    // Clear beats enable
    @(negedge clk);
    clr = 1'b1;
    tick();
    check("clr_over_en", 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) tick();
    check("reach_6", 4'd6, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_async", 4'd0, 1'b0);
    tick();
    check("rst_dominates_en", 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("resume_%0d", i), 4'(i), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loop_counter.md
Name: loop_counter

Overview:
Parameterised modulo-N loop counter for the CNN accelerator control path (kernel/row/column/channel loop indices). Counts 0..N-1 while enabled, wraps to 0, and flags the terminal count on a carry-out. The carry-out lets controllers detect loop completion and chain counters for nested loops.

Parameters:
N, 10, loop length (modulus); counter visits 0..N-1; legal N >= 2.
CNT_W, $clog2(N) (minimum 1), width of cnt; 4 for the default N=10; derived, not overridden by users.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high; forces cnt to 0.
en  input  1  count enable; increments cnt once per clock when high.
clr  input  1  synchronous clear; loads cnt with 0 on next rising edge.
co  output  1  carry-out / terminal-count flag; high when cnt == N-1.
cnt  output  CNT_W  current loop index, 0..N-1.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high on rst.
- rst high at any time: cnt = 0 immediately, without waiting for a clock edge; co = 0 (N >= 2). rst dominates all other inputs while asserted.
- Registered counter; priority on each rising clk with rst low:
  - clr=1: cnt <= 0, regardless of en.
  - else en=1 and cnt == N-1: cnt <= 0 (wrap).
  - else en=1: cnt <= cnt + 1.
  - else: cnt holds.
- co is combinational from the register: co = (cnt == N-1). It is independent of en:
  - co stays high while the counter is parked at N-1 with en=0.
  - co falls the cycle after a wrap or clear.
- Latency: cnt changes one clock after the en/clr sampling edge. co follows cnt with no further delay.
- With en held high: the period is exactly N clocks, and co is high for 1 of every N clocks.
- Mid-count reset or clear: cnt returns to 0; counting resumes from 0 on the next enabled edge.
- cnt must never exceed N-1. Out-of-range register values are unreachable; if forced, the next enabled edge increments normally.
- No internal state other than the cnt register.

Test Plan:
1. Reset: en=0, pulse rst high with clk running -> cnt=0 and co=0 immediately (asynchronously), and both hold after rst falls.
2. Count up, N=10: en=1 from cnt=0 -> cnt goes 1,2,...,9 on successive edges; co rises exactly when cnt=9 (9th edge after en) and is low for cnt 0..8.
3. Wrap: keep en=1 past cnt=9 -> next edge cnt=0, co=0; a second co pulse occurs 10 clocks after the first.
4. Hold at terminal count: at cnt=9 drop en -> cnt stays 9, co stays 1 for all following cycles.
5. Clear: from cnt=9 with en=0, assert clr for one edge -> cnt=0, co=0. Set en=1 -> co rises again after 9 edges. clr=1 with en=1 at cnt=5 -> cnt=0, so clr wins over en.
6. Async reset mid-count: at cnt=6 with en=1, assert rst between edges -> cnt=0 before the next edge. Release rst -> counting resumes 1,2,...
